mul_seq_ctrl: RTL and testbench

//  - Sequencer that time-shares one 4x4 wallace_tree_multiplier to form a WxW product, one nibble pair per cycle.
//  - Accumulates shifted 8-bit partial products into a 2W-bit result.
//  - Sits between a valid/ready requester and its consumer: one operation in flight, no pipelining between operations.

---
 rtl/mul_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequential WxW multiplier: one 4x4 nibble product per cycle, shifted
// and summed into a 2W-bit accumulator. Optional MUL_SIGNED_EN adds sgn/NEG.
module mul_seq_ctrl #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
`ifdef MUL_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int NIB = W / 4;
  localparam int NW  = $clog2(NIB + 1);
  localparam int P   = 2 * W;
  localparam logic [NW-1:0] LAST = NW'(NIB - 1);

`ifdef MUL_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, NEG, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t        state_q, state_d;
  logic [W-1:0]  a_r, b_r;
  logic [P-1:0]  acc;
  logic [NW-1:0] ni, nj;
  logic [3:0]    a_nib, b_nib;
  logic [7:0]    pp;
  logic [NW:0]   pos;
  logic [P-1:0]  part;
`ifdef MUL_SIGNED_EN
  logic          neg;
`endif

  // 4x4 nibble multiplier shared by every step; 15*15 fits in 8 bits
  function automatic logic [7:0] mul4(input logic [3:0] x,
                                      input logic [3:0] y);
    return 8'(x) * 8'(y);
  endfunction

  // Select the current nibble pair and place its product at 4*(i+j)
  always_comb begin
    a_nib = 4'(a_r >> {ni, 2'b00});
    b_nib = 4'(b_r >> {nj, 2'b00});
    pp    = mul4(a_nib, b_nib);
    pos   = {1'b0, ni} + {1'b0, nj};
    part  = P'(pp) << {pos, 2'b00};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (ni == LAST && nj == LAST) begin
`ifdef MUL_SIGNED_EN
          state_d = neg ? NEG : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      NEG: state_d = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, step counters and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      ni  <= '0;
      nj  <= '0;
`ifdef MUL_SIGNED_EN
      neg <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
`ifdef MUL_SIGNED_EN
            a_r <= (sgn && a[W-1]) ? -a : a;
            b_r <= (sgn && b[W-1]) ? -b : b;
            neg <= sgn & (a[W-1] ^ b[W-1]);
`else
            a_r <= a;
            b_r <= b;
`endif
            acc <= '0;
            ni  <= '0;
            nj  <= '0;
          end
        end
        RUN: begin
          acc <= acc + part;
          if (ni == LAST) begin
            ni <= '0;
            nj <= nj + NW'(1);
          end else begin
            ni <= ni + NW'(1);
          end
        end
`ifdef MUL_SIGNED_EN
        NEG: acc <= -acc;
`endif
        default: ;
      endcase
    end
  end

  assign p = acc;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Randomized self-checking bench for mul_seq_ctrl.
// Reference: integer product of the operands and the expected latency.
module tb_mul_seq_ctrl;

  localparam int W = 8;
  localparam int P = 2 * W;
  localparam int S = (W / 4) * (W / 4);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [P-1:0] p;
  logic         busy;
`ifdef MUL_SIGNED_EN
  logic         sgn = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
`ifdef MUL_SIGNED_EN
    .sgn(sgn),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p(p),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] x,
                                        input logic [W-1:0] y,
                                        input logic s);
    longint xv = longint'(x);
    longint yv = longint'(y);
    longint mask = (longint'(1) << P) - 1;
    if (s && x[W-1]) xv = xv - (longint'(1) << W);
    if (s && y[W-1]) yv = yv - (longint'(1) << W);
    return 64'((xv * yv) & mask);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick;
    unique case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return W'(1) << (W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic ts,
                        input int hold, input logic flood);
    logic [63:0]  ev;
    int           el;
    int           n;
    logic [P-1:0] held;
    ev = model(ta, tb, ts);
    el = S + ((ts && (ta[W-1] ^ tb[W-1])) ? 1 : 0);
    n  = 0;
    chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
    a = ta;
    b = tb;
`ifdef MUL_SIGNED_EN
    sgn = ts;
`endif
    in_valid = 1'b1;
    tick;
    in_valid = flood;
    chk({tag, ".busy"}, 64'(busy), 64'(1));
    chk({tag, ".nrdy"}, 64'(in_ready), 64'(0));
    while (!out_valid && n < 40) begin
      if (flood) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      tick;
      n++;
    end
    chk({tag, ".lat"}, 64'(n), 64'(el));
    chk({tag, ".p"}, 64'(p), ev);
    held = p;
    repeat (hold) begin
      a = W'($urandom);
      tick;
      chk({tag, ".hold_p"}, 64'(p), 64'(held));
      chk({tag, ".hold_v"}, 64'(out_valid), 64'(1));
      chk({tag, ".hold_r"}, 64'(in_ready), 64'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, ".ov0"}, 64'(out_valid), 64'(0));
    chk({tag, ".rdy1"}, 64'(in_ready), 64'(1));
    chk({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst.rdy", 64'(in_ready), 64'(1));
    chk("rst.ov", 64'(out_valid), 64'(0));
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.p", 64'(p), 64'(0));
    #10 rst = 1'b0;
    tick;

    // Asynchronous reset while a result is waiting
    a = 2;
    b = 3;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (S) tick;
    chk("t1.ov", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t1.p", 64'(p), 64'(0));
    chk("t1.ov", 64'(out_valid), 64'(0));
    chk("t1.rdy", 64'(in_ready), 64'(1));
    chk("t1.busy", 64'(busy), 64'(0));
    #2 rst = 1'b0;
    tick;

    run_op("t2", 7, 5, 1'b0, 0, 1'b0);
    run_op("t3", 255, 255, 1'b0, 5, 1'b1);
    run_op("t4a", 0, 200, 1'b0, 0, 1'b0);
    run_op("t4b", 16, 16, 1'b0, 0, 1'b0);
    run_op("t4c", 15, 15, 1'b0, 1, 1'b0);

    // Reset after two RUN steps abandons the operation
    a = 9;
    b = 7;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #2 rst = 1'b1;
    #1;
    chk("t5.rdy", 64'(in_ready), 64'(1));
    chk("t5.busy", 64'(busy), 64'(0));
    #2 rst = 1'b0;
    repeat (6) begin
      tick;
      chk("t5.nov", 64'(out_valid), 64'(0));
    end
    run_op("t5b", 3, 4, 1'b0, 0, 1'b0);

`ifdef MUL_SIGNED_EN
    run_op("s1", 8'hFB, 8'd4, 1'b1, 0, 1'b0);
    run_op("s2", 8'h80, 8'h80, 1'b1, 0, 1'b0);
    run_op("s3", 8'hF9, 8'd7, 1'b0, 0, 1'b0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic ts;
`ifdef MUL_SIGNED_EN
      ts = 1'($urandom_range(0, 1));
`else
      ts = 1'b0;
`endif
      run_op("rnd", pick(), pick(), ts, $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
